psum_feeder: RTL and testbench

PSUM_FEEDER -- requirements
Module: psum_feeder

---
 rtl/psum_feeder.sv | 230 +++++++++++++++++++++++
 tb/tb_psum_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_feeder.sv
// psum_feeder: buffers signed words from the MAC array in a small FIFO and
// sequences them into an external sfp accumulator, one group of kij words at
// a time. Each group is cleared, accumulated, optionally relu-clamped and
// then captured.
//
// Ports:
//   clk, reset      sole clock (rising edge), asynchronous active-high reset
//   wr, in          push a bw-bit signed word into the FIFO
//   hold            inhibit pops and accumulate strobes
//   relu_en         emit a relu strobe at the end of each group
//   sfp_out         accumulated result fed back from the sfp
//   full, empty     FIFO occupancy flags
//   overflow        sticky: a write was attempted while full
//   sfp_in, acc     registered data word and accumulate strobe to the sfp
//   relu, sfp_clr   registered relu strobe and clear to the sfp
//   out, out_valid  captured group result and its one-cycle update pulse
module psum_feeder #(
  parameter int bw      = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8,
  parameter int kij     = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [bw-1:0]      in,
  input  logic               hold,
  input  logic               relu_en,
  input  logic [psum_bw-1:0] sfp_out,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [bw-1:0]      sfp_in,
  output logic               acc,
  output logic               relu,
  output logic               sfp_clr,
  output logic [psum_bw-1:0] out,
  output logic               out_valid
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(kij + 1);
  localparam logic [cw-1:0] last_c = cw'(kij - 1);

  typedef enum logic [2:0] {
    st_clr  = 3'd0,
    st_acc  = 3'd1,
    st_relu = 3'd2,
    st_wait = 3'd3,
    st_cap  = 3'd4
  } state_t;

  logic [bw-1:0]      mem_r [depth];
  logic [aw-1:0]      wr_ptr_r;
  logic [aw-1:0]      rd_ptr_r;
  logic [aw:0]        count_r;
  logic [aw:0]        count_next_s;
  logic               full_r;
  logic               empty_r;
  logic               overflow_r;
  logic               push_s;
  logic               take_s;

  state_t             state_r;
  state_t             state_next_s;
  logic [cw-1:0]      cnt_r;
  logic [cw-1:0]      cnt_next_s;
  logic [bw-1:0]      sfp_in_r;
  logic [bw-1:0]      sfp_in_next_s;
  logic               acc_r;
  logic               acc_next_s;
  logic               relu_r;
  logic               relu_next_s;
  logic               clr_r;
  logic               clr_next_s;
  logic [psum_bw-1:0] out_r;
  logic [psum_bw-1:0] out_next_s;
  logic               out_valid_r;
  logic               out_valid_next_s;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push_s = wr & ~full_r;
  // The head word is consumed only while accumulating, not held, and present.
  assign take_s = (state_r == st_acc) & ~empty_r & ~hold;

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !take_s) begin
      count_next_s = count_r + (aw+1)'(1);
    end else if (!push_s && take_s) begin
      count_next_s = count_r - (aw+1)'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in;
    end
  end

  // FIFO pointers, occupancy, registered flags and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= aw'(0);
      rd_ptr_r   <= aw'(0);
      count_r    <= (aw+1)'(0);
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + aw'(1);
      end
      if (take_s) begin
        rd_ptr_r <= rd_ptr_r + aw'(1);
      end
      count_r    <= count_next_s;
      full_r     <= (count_next_s == (aw+1)'(depth));
      empty_r    <= (count_next_s == (aw+1)'(0));
      overflow_r <= overflow_r | (wr & full_r);
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= st_clr;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      st_clr:  state_next_s = st_acc;
      st_acc: begin
        if (take_s && (cnt_r == last_c)) begin
          state_next_s = st_relu;
        end else begin
          state_next_s = st_acc;
        end
      end
      st_relu: state_next_s = st_wait;
      st_wait: state_next_s = st_cap;
      st_cap:  state_next_s = st_acc;
      default: state_next_s = st_clr;
    endcase
  end

  // Sequencer output logic: next values of the registered strobes and data.
  always_comb begin
    cnt_next_s       = cnt_r;
    sfp_in_next_s    = sfp_in_r;
    acc_next_s       = 1'b0;
    relu_next_s      = 1'b0;
    clr_next_s       = 1'b0;
    out_next_s       = out_r;
    out_valid_next_s = 1'b0;
    case (state_r)
      st_clr: begin
        clr_next_s = 1'b0;
      end
      st_acc: begin
        // Stalls leave sfp_in untouched and acc low so no bubble is summed.
        if (take_s) begin
          sfp_in_next_s = mem_r[rd_ptr_r];
          acc_next_s    = 1'b1;
          cnt_next_s    = cnt_r + cw'(1);
        end else begin
          cnt_next_s    = cnt_r;
        end
      end
      st_relu: begin
        relu_next_s = relu_en;
      end
      st_wait: begin
        relu_next_s = 1'b0;
      end
      st_cap: begin
        // sfp_out already includes the relu applied two edges earlier.
        out_next_s       = sfp_out;
        out_valid_next_s = 1'b1;
        clr_next_s       = 1'b1;
        cnt_next_s       = cw'(0);
      end
      default: begin
        clr_next_s = 1'b1;
        cnt_next_s = cw'(0);
      end
    endcase
  end

  // Registered sequencer outputs and group counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= cw'(0);
      sfp_in_r    <= bw'(0);
      acc_r       <= 1'b0;
      relu_r      <= 1'b0;
      clr_r       <= 1'b1;
      out_r       <= psum_bw'(0);
      out_valid_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_next_s;
      sfp_in_r    <= sfp_in_next_s;
      acc_r       <= acc_next_s;
      relu_r      <= relu_next_s;
      clr_r       <= clr_next_s;
      out_r       <= out_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;
  assign sfp_in    = sfp_in_r;
  assign acc       = acc_r;
  assign relu      = relu_r;
  assign sfp_clr   = clr_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_psum_feeder.sv
// Testbench for psum_feeder: two instances (kij=3 and kij=1), each paired
// with a small behavioural sfp accumulator (thres=0). Expected sfp_in words
// and group results are queued when stimulus is driven and compared when
// the design strobes acc or out_valid.
module tb_psum_feeder;

  logic        clk;
  logic        reset;
  logic        wr, hold, relu_en;
  logic [7:0]  in;
  logic [15:0] sfp_out;
  logic        full, empty, overflow, acc, relu, sfp_clr, out_valid;
  logic [7:0]  sfp_in;
  logic [15:0] out;
  logic [15:0] psum;

  logic        wr1, hold1, relu_en1;
  logic [7:0]  in1;
  logic [15:0] sfp_out1;
  logic        full1, empty1, overflow1, acc1, relu1, sfp_clr1, out_valid1;
  logic [7:0]  sfp_in1;
  logic [15:0] out1;
  logic [15:0] psum1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int acc_total = 0;
  int ov_total = 0;
  int acc1_total = 0;

  logic [7:0]  acc_q[$];
  logic [15:0] out_q[$];
  logic [15:0] out1_q[$];

  psum_feeder #(.bw(8), .psum_bw(16), .depth(8), .kij(3)) u_dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .hold(hold), .relu_en(relu_en),
    .sfp_out(sfp_out), .full(full), .empty(empty), .overflow(overflow),
    .sfp_in(sfp_in), .acc(acc), .relu(relu), .sfp_clr(sfp_clr), .out(out),
    .out_valid(out_valid));

  psum_feeder #(.bw(8), .psum_bw(16), .depth(8), .kij(1)) u_dut1 (
    .clk(clk), .reset(reset), .wr(wr1), .in(in1), .hold(hold1), .relu_en(relu_en1),
    .sfp_out(sfp_out1), .full(full1), .empty(empty1), .overflow(overflow1),
    .sfp_in(sfp_in1), .acc(acc1), .relu(relu1), .sfp_clr(sfp_clr1), .out(out1),
    .out_valid(out_valid1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural sfp models: clear, accumulate sign-extended word, relu at 0.
  always @(posedge clk) begin
    if (sfp_clr) psum <= 16'd0;
    else if (acc) psum <= psum + {{8{sfp_in[7]}}, sfp_in};
    else if (relu && psum[15]) psum <= 16'd0;
    if (sfp_clr1) psum1 <= 16'd0;
    else if (acc1) psum1 <= psum1 + {{8{sfp_in1[7]}}, sfp_in1};
    else if (relu1 && psum1[15]) psum1 <= 16'd0;
  end
  assign sfp_out  = psum;
  assign sfp_out1 = psum1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (acc) begin
        acc_total++;
        last_acc_cyc = cyc;
        if (acc_q.size() == 0) check("acc_spurious", 32'd1, 32'd0);
        else check("sfp_in", {24'd0, sfp_in}, {24'd0, acc_q.pop_front()});
      end
      if (out_valid) begin
        ov_total++;
        check("latency", cyc - last_acc_cyc, 32'd3);
        if (out_q.size() == 0) check("out_valid_spurious", 32'd1, 32'd0);
        else check("out", {16'd0, out}, {16'd0, out_q.pop_front()});
      end
      if (acc1) acc1_total++;
      if (out_valid1) begin
        if (out1_q.size() == 0) check("out1_valid_spurious", 32'd1, 32'd0);
        else check("out1", {16'd0, out1}, {16'd0, out1_q.pop_front()});
      end
    end
  end

  task automatic put(input int v, input bit popped);
    @(negedge clk);
    wr = 1'b1;
    in = v[7:0];
    if (popped) acc_q.push_back(v[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((out_q.size() != 0 || acc_q.size() != 0 || out1_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (n < 400)}, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_empty"},    {31'd0, empty},     32'd1);
    check({tag, "_full"},     {31'd0, full},      32'd0);
    check({tag, "_overflow"}, {31'd0, overflow},  32'd0);
    check({tag, "_acc"},      {31'd0, acc},       32'd0);
    check({tag, "_relu"},     {31'd0, relu},      32'd0);
    check({tag, "_sfp_clr"},  {31'd0, sfp_clr},   32'd1);
    check({tag, "_sfp_in"},   {24'd0, sfp_in},    32'd0);
    check({tag, "_out"},      {16'd0, out},       32'd0);
    check({tag, "_out_valid"},{31'd0, out_valid}, 32'd0);
    check({tag, "_empty1"},   {31'd0, empty1},    32'd1);
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1; wr = 1'b0; in = 8'd0; hold = 1'b0; relu_en = 1'b1;
    wr1 = 1'b0; in1 = 8'd0; hold1 = 1'b0; relu_en1 = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    reset = 1'b0;

    // Basic group: 5 - 2 + 4 = 7.
    base = acc_total;
    out_q.push_back(16'd7);
    put(5, 1); put(-2, 1); put(4, 1); idle(1);
    drain("drain_g1");
    check("g1_accs", acc_total - base, 32'd3);

    // Negative sum clamped by relu, then passed through without relu.
    out_q.push_back(16'd0);
    put(-3, 1); put(-4, 1); put(1, 1); idle(1);
    drain("drain_g2");
    relu_en = 1'b0;
    out_q.push_back(16'hFFFA);
    put(-3, 1); put(-4, 1); put(1, 1); idle(1);
    drain("drain_g3");
    relu_en = 1'b1;

    // Write gaps: acc must stay low while the FIFO is empty.
    base = acc_total;
    out_q.push_back(16'd7);
    put(5, 1); idle(2); put(-2, 1); idle(2); put(4, 1); idle(1);
    drain("drain_gap");
    check("gap_accs", acc_total - base, 32'd3);
    base = ov_total;
    idle(10);
    check("gap_out_hold", {16'd0, out}, 32'd7);
    check("gap_no_extra", ov_total - base, 32'd0);

    // Fill under hold: full after 8 words, 9th dropped and flags overflow.
    @(negedge clk);
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 7) check("fill7_full", {31'd0, full}, 32'd0);
      if (i == 8) begin
        check("fill8_full", {31'd0, full}, 32'd1);
        check("fill8_overflow", {31'd0, overflow}, 32'd0);
      end
      wr = 1'b1;
      in = 8'(i + 1);
      if (i < 8) acc_q.push_back(8'(i + 1));
    end
    @(negedge clk);
    wr = 1'b0;
    check("fill9_full", {31'd0, full}, 32'd1);
    check("fill9_empty", {31'd0, empty}, 32'd0);
    check("fill9_overflow", {31'd0, overflow}, 32'd1);
    check("hold_no_acc", {31'd0, acc}, 32'd0);
    base = acc_total;
    out_q.push_back(16'd6);
    out_q.push_back(16'd15);
    out_q.push_back(16'd25);
    hold = 1'b0;
    @(negedge clk);
    put(10, 1); idle(1);
    drain("drain_fill");
    check("fill_accs", acc_total - base, 32'd9);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-group with a word still queued; nothing may be captured.
    base = acc_total;
    put(3, 1); put(3, 1); idle(1);
    n = 0;
    while (acc_total < base + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_accs", acc_total - base, 32'd2);
    hold = 1'b1;
    put(5, 0); idle(1);
    check("mid_queued", {31'd0, empty}, 32'd0);
    reset = 1'b1;
    acc_q.delete();
    @(negedge clk);
    check_reset("rst1");
    @(negedge clk);
    reset = 1'b0;
    hold = 1'b0;
    base = ov_total;
    idle(8);
    check("rst_no_out_valid", ov_total - base, 32'd0);
    check("rst_no_acc", {31'd0, acc}, 32'd0);
    out_q.push_back(16'd3);
    put(1, 1); put(1, 1); put(1, 1); idle(1);
    drain("drain_after_rst");

    // kij=1 instance: each word is its own group.
    out1_q.push_back(16'd2);
    out1_q.push_back(16'd0);
    @(negedge clk);
    wr1 = 1'b1; in1 = 8'd2;
    @(negedge clk);
    in1 = 8'hFF;
    @(negedge clk);
    wr1 = 1'b0;
    drain("drain_kij1");
    check("kij1_accs", acc1_total, 32'd2);
    check("kij1_out_final", {16'd0, out1}, 32'd0);
    check("kij1_empty", {31'd0, empty1}, 32'd1);
    check("kij1_full", {31'd0, full1}, 32'd0);
    check("kij1_overflow", {31'd0, overflow1}, 32'd0);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
